// File: rtl/llcrd_ack_pkg.sv
// Shared constants and state encoding for the LLCRD ack scheduler.
package llcrd_ack_pkg;

  localparam int ACK_THRESH = 8;
  localparam int ACK_CNT_W  = 8;

  typedef enum logic {
    IDLE      = 1'b0,
    LLCRD_REQ = 1'b1
  } ack_sched_state_e;

endpackage

// File: rtl/ack_timeout_timer.sv
// Purpose: saturating idle-ack timer; expire fires when the last count would increment.
// Latency: expire is combinational from inc and the registered count.
// Backpressure: none; inc/clr are sampled every cycle, clr wins over inc.
module ack_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);

  logic [TIMER_W-1:0] timer_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer_q <= '0;
    end else if (clr) begin
      timer_q <= '0;
    end else if (inc && (timer_q != TIMER_MAX)) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Must not depend on clr: the caller folds expire into its clear term.
  assign expire = inc && (timer_q == TIMER_LAST);

endmodule

// File: rtl/llcrd_ack_scheduler.sv
// Purpose: returns RX acks via header Ack-bit piggyback or a full-ack LLCRD flit request.
// Latency: piggyback 0 cycles; LLCRD valid 1 cycle after force or timer expiry.
// Backpressure: tx_llcrd_valid holds until tx_llcrd_ready; piggyback is blocked meanwhile.
module llcrd_ack_scheduler
  import llcrd_ack_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 retry_set_ack_bit,
  input  logic [ACK_CNT_W-1:0] retry_num_ack,
  input  logic                 llr_state_normal,
  input  logic                 tx_hdr_slot_valid,
  input  logic                 i_force_full_ack,
  output logic                 o_tx_ack_bit,
  output logic                 controller_dec_num_ack,
  output logic                 tx_llcrd_valid,
  input  logic                 tx_llcrd_ready,
  output logic [ACK_CNT_W-1:0] tx_llcrd_full_ack,
  output logic                 controller_llcrd_full_ack_sent
);

  ack_sched_state_e state_q, state_d;

  logic has_ack;
  logic piggy;
  logic timer_inc;
  logic timer_clr;
  logic timer_expire;
  logic go_req;
  logic llcrd_hs;

  assign has_ack   = (retry_num_ack != '0);
  assign piggy     = (state_q == IDLE) && llr_state_normal && tx_hdr_slot_valid && retry_set_ack_bit;
  assign timer_inc = (state_q == IDLE) && llr_state_normal && has_ack && !piggy;
  assign timer_clr = piggy || !has_ack || go_req;

  ack_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .inc    (timer_inc),
    .clr    (timer_clr),
    .expire (timer_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    go_req   = 1'b0;
    llcrd_hs = 1'b0;
    case (state_q)
      IDLE: begin
        // Force and piggyback may coincide; the LLCRD then carries the remainder.
        if (has_ack && (timer_expire || i_force_full_ack)) begin
          go_req  = 1'b1;
          state_d = LLCRD_REQ;
        end
      end
      LLCRD_REQ: begin
        if (tx_llcrd_ready) begin
          llcrd_hs = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_tx_ack_bit                   = piggy;
  assign controller_dec_num_ack         = piggy;
  assign tx_llcrd_valid                 = (state_q == LLCRD_REQ);
  assign tx_llcrd_full_ack              = retry_num_ack;
  assign controller_llcrd_full_ack_sent = llcrd_hs;

endmodule

// File: tb/tb_llcrd_ack_scheduler.sv
// Directed bench for llcrd_ack_scheduler with a short timeout.
module tb_llcrd_ack_scheduler;
  import llcrd_ack_pkg::*;

  localparam int TO = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       retry_set_ack_bit;
  logic [7:0] retry_num_ack;
  logic       llr_state_normal;
  logic       tx_hdr_slot_valid;
  logic       i_force_full_ack;
  logic       o_tx_ack_bit;
  logic       controller_dec_num_ack;
  logic       tx_llcrd_valid;
  logic       tx_llcrd_ready;
  logic [7:0] tx_llcrd_full_ack;
  logic       controller_llcrd_full_ack_sent;

  int tests = 0;
  int fails = 0;

  llcrd_ack_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk                          (i_clk),
    .i_rst_n                        (i_rst_n),
    .retry_set_ack_bit              (retry_set_ack_bit),
    .retry_num_ack                  (retry_num_ack),
    .llr_state_normal               (llr_state_normal),
    .tx_hdr_slot_valid              (tx_hdr_slot_valid),
    .i_force_full_ack               (i_force_full_ack),
    .o_tx_ack_bit                   (o_tx_ack_bit),
    .controller_dec_num_ack         (controller_dec_num_ack),
    .tx_llcrd_valid                 (tx_llcrd_valid),
    .tx_llcrd_ready                 (tx_llcrd_ready),
    .tx_llcrd_full_ack              (tx_llcrd_full_ack),
    .controller_llcrd_full_ack_sent (controller_llcrd_full_ack_sent)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst_n           = 1'b0;
    retry_set_ack_bit = 1'b0;
    retry_num_ack     = 8'd0;
    llr_state_normal  = 1'b0;
    tx_hdr_slot_valid = 1'b0;
    i_force_full_ack  = 1'b0;
    tx_llcrd_ready    = 1'b0;
    #2;
    chk("rst_valid", 32'(tx_llcrd_valid), 32'd0);
    chk("rst_ack_bit", 32'(o_tx_ack_bit), 32'd0);
    chk("rst_dec", 32'(controller_dec_num_ack), 32'd0);
    chk("rst_sent", 32'(controller_llcrd_full_ack_sent), 32'd0);
    chk("rst_full_ack", 32'(tx_llcrd_full_ack), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_timer", 32'(dut.u_timer.timer_q), 32'd0);
    tick();
    tick();
    i_rst_n = 1'b1;

    // Piggyback after the timer has run two cycles
    tick();
    llr_state_normal  = 1'b1;
    retry_num_ack     = 8'd9;
    retry_set_ack_bit = 1'b1;
    #1 chk("pb_no_hdr", 32'(o_tx_ack_bit), 32'd0);
    tick();
    tick();
    tx_hdr_slot_valid = 1'b1;
    #1;
    chk("pb_timer_pre", 32'(dut.u_timer.timer_q), 32'd2);
    chk("pb_ack_bit", 32'(o_tx_ack_bit), 32'd1);
    chk("pb_dec", 32'(controller_dec_num_ack), 32'd1);
    chk("pb_valid", 32'(tx_llcrd_valid), 32'd0);
    tick();
    tx_hdr_slot_valid = 1'b0;
    retry_num_ack     = 8'd1;
    retry_set_ack_bit = 1'b0;
    #1;
    chk("pb_timer_clr", 32'(dut.u_timer.timer_q), 32'd0);
    chk("pb_ack_low", 32'(o_tx_ack_bit), 32'd0);
    tick();
    retry_num_ack = 8'd0;

    // Timeout: count 3 from cycle 0, valid expected in cycle TO
    tick();
    retry_num_ack = 8'd3;
    for (int c = 0; c < TO; c++) begin
      #1 chk("to_wait_valid", 32'(tx_llcrd_valid), 32'd0);
      tick();
    end
    #1 chk("to_valid_c4", 32'(tx_llcrd_valid), 32'd1);
    tick();
    #1;
    chk("to_valid_c5", 32'(tx_llcrd_valid), 32'd1);
    chk("to_sent_c5", 32'(controller_llcrd_full_ack_sent), 32'd0);
    tick();
    #1 chk("to_valid_c6", 32'(tx_llcrd_valid), 32'd1);
    tick();
    tx_llcrd_ready = 1'b1;
    #1;
    chk("to_sent_c7", 32'(controller_llcrd_full_ack_sent), 32'd1);
    chk("to_full_ack_c7", 32'(tx_llcrd_full_ack), 32'd3);
    tick();
    tx_llcrd_ready = 1'b0;
    #1;
    chk("to_valid_c8", 32'(tx_llcrd_valid), 32'd0);
    chk("to_state_c8", 32'(dut.state_q), 32'(IDLE));
    chk("to_sent_c8", 32'(controller_llcrd_full_ack_sent), 32'd0);

    // Suppression of piggyback while a request is pending
    retry_num_ack     = 8'd12;
    retry_set_ack_bit = 1'b1;
    i_force_full_ack  = 1'b1;
    #1 chk("sup_force_cycle_valid", 32'(tx_llcrd_valid), 32'd0);
    tick();
    i_force_full_ack  = 1'b0;
    tx_hdr_slot_valid = 1'b1;
    #1;
    chk("sup_valid", 32'(tx_llcrd_valid), 32'd1);
    chk("sup_ack_bit", 32'(o_tx_ack_bit), 32'd0);
    chk("sup_dec", 32'(controller_dec_num_ack), 32'd0);
    chk("sup_full_ack", 32'(tx_llcrd_full_ack), 32'd12);
    tick();
    tx_llcrd_ready = 1'b1;
    #1;
    chk("sup_sent", 32'(controller_llcrd_full_ack_sent), 32'd1);
    chk("sup_hs_ack_bit", 32'(o_tx_ack_bit), 32'd0);
    tick();
    tx_llcrd_ready    = 1'b0;
    tx_hdr_slot_valid = 1'b0;
    retry_num_ack     = 8'd0;
    retry_set_ack_bit = 1'b0;
    #1 chk("sup_after_valid", 32'(tx_llcrd_valid), 32'd0);

    // Force ignored with zero count
    tick();
    i_force_full_ack = 1'b1;
    tick();
    i_force_full_ack = 1'b0;
    #1 chk("force0_valid", 32'(tx_llcrd_valid), 32'd0);

    // Force with count 5
    tick();
    retry_num_ack    = 8'd5;
    i_force_full_ack = 1'b1;
    #1 chk("force5_same_cycle", 32'(tx_llcrd_valid), 32'd0);
    tick();
    i_force_full_ack = 1'b0;
    #1;
    chk("force5_valid", 32'(tx_llcrd_valid), 32'd1);
    chk("force5_full_ack", 32'(tx_llcrd_full_ack), 32'd5);
    tick();
    tx_llcrd_ready = 1'b1;
    #1 chk("force5_sent", 32'(controller_llcrd_full_ack_sent), 32'd1);
    tick();
    tx_llcrd_ready = 1'b0;
    retry_num_ack  = 8'd0;
    #1;
    chk("force5_sent_once", 32'(controller_llcrd_full_ack_sent), 32'd0);
    chk("force5_idle", 32'(tx_llcrd_valid), 32'd0);

    // Force and piggyback in the same cycle both take effect
    tick();
    retry_num_ack     = 8'd10;
    retry_set_ack_bit = 1'b1;
    tx_hdr_slot_valid = 1'b1;
    i_force_full_ack  = 1'b1;
    #1;
    chk("fp_ack_bit", 32'(o_tx_ack_bit), 32'd1);
    chk("fp_dec", 32'(controller_dec_num_ack), 32'd1);
    tick();
    i_force_full_ack  = 1'b0;
    tx_hdr_slot_valid = 1'b0;
    retry_set_ack_bit = 1'b0;
    retry_num_ack     = 8'd2;
    #1;
    chk("fp_valid", 32'(tx_llcrd_valid), 32'd1);
    chk("fp_full_ack", 32'(tx_llcrd_full_ack), 32'd2);
    tick();
    tx_llcrd_ready = 1'b1;
    #1 chk("fp_sent", 32'(controller_llcrd_full_ack_sent), 32'd1);
    tick();
    tx_llcrd_ready = 1'b0;
    retry_num_ack  = 8'd0;

    // Stall: normal drops for 10 cycles with timer at 2
    tick();
    retry_num_ack     = 8'd9;
    retry_set_ack_bit = 1'b1;
    llr_state_normal  = 1'b1;
    tick();
    tick();
    llr_state_normal  = 1'b0;
    tx_hdr_slot_valid = 1'b1;
    for (int s = 0; s < 10; s++) begin
      #1;
      chk("stall_ack_bit", 32'(o_tx_ack_bit), 32'd0);
      chk("stall_valid", 32'(tx_llcrd_valid), 32'd0);
      tick();
    end
    llr_state_normal  = 1'b1;
    tx_hdr_slot_valid = 1'b0;
    #1;
    chk("stall_timer_frozen", 32'(dut.u_timer.timer_q), 32'd2);
    chk("stall_valid_c12", 32'(tx_llcrd_valid), 32'd0);
    tick();
    #1 chk("stall_valid_c13", 32'(tx_llcrd_valid), 32'd0);
    tick();
    #1 chk("stall_valid_c14", 32'(tx_llcrd_valid), 32'd1);

    // Asynchronous reset while the request is pending
    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_llcrd_valid), 32'd0);
    chk("arst_sent", 32'(controller_llcrd_full_ack_sent), 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
    chk("arst_timer", 32'(dut.u_timer.timer_q), 32'd0);
    tick();
    i_rst_n           = 1'b1;
    llr_state_normal  = 1'b0;
    retry_num_ack     = 8'd0;
    retry_set_ack_bit = 1'b0;
    tick();
    #1 chk("post_rst_valid", 32'(tx_llcrd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
